// File: rtl/ram_stream_if.sv
// Bundle between ram_stream, its append producer, its stream consumer and the
// single-port RAM (async read, sync write).
interface ram_stream_if #(
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 8
);
   logic                  append_valid;
   logic [WIDTH-1:0]      append_data;
   logic                  append_ready;

   logic                  out_valid;
   logic [WIDTH-1:0]      out_data;
   logic                  out_last;
   logic                  out_ready;

   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [WIDTH-1:0]      ram_din;
   logic                  ram_we;
   logic [WIDTH-1:0]      ram_dout;

   // Controller side
   modport master (
      input  append_valid, append_data, out_ready, ram_dout,
      output append_ready, out_valid, out_data, out_last, ram_addr, ram_din, ram_we
   );

   // Environment side: producer, consumer and RAM
   modport slave (
      output append_valid, append_data, out_ready, ram_dout,
      input  append_ready, out_valid, out_data, out_last, ram_addr, ram_din, ram_we
   );
endinterface

// File: rtl/ram_stream.sv
// Append/scan front-end for a single-port RAM: writes words at the fill pointer
// and streams entries 0..count-1 back on a registered valid/ready output.
module ram_stream #(
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ram_stream_if.master          bus,
   input  logic                  scan_start,
   input  logic                  clear,
   output logic                  busy,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full
);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DRAIN
   } state_t;

   localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic                  append_fire;
   logic                  fetch;
   logic                  fetch_last;
   logic                  out_fire;

   assign full             = (count == DEPTH);
   assign busy             = (state != IDLE);
   assign bus.append_ready = (state == IDLE) && !full && !scan_start && !clear;
   assign append_fire      = bus.append_valid && bus.append_ready;

   // A fetch refills the output register whenever it is empty or being drained.
   assign fetch      = (state == SCAN) && (!bus.out_valid || bus.out_ready);
   // Full-width compare so a completely full table does not alias rd_ptr to 0.
   assign fetch_last = fetch && (rd_ptr == count - 1'b1);
   assign out_fire   = bus.out_valid && bus.out_ready;

   assign bus.ram_we   = append_fire;
   assign bus.ram_din  = bus.append_data;
   assign bus.ram_addr = (state == SCAN) ? rd_ptr[ADDR_WIDTH-1:0] : count[ADDR_WIDTH-1:0];

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: the default assignment first guarantees no latch on any path.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (scan_start && count != '0) state_nxt = SCAN;
         SCAN:    if (fetch_last)                state_nxt = DRAIN;
         DRAIN:   if (out_fire)                  state_nxt = IDLE;
         default:                                state_nxt = IDLE;
      endcase
   end

   // Only IDLE may change count, which keeps it constant for the whole scan.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (state == IDLE) begin
         if (clear && !scan_start) count <= '0;
         else if (append_fire)     count <= count + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         rd_ptr <= '0;
      else if (state == IDLE && scan_start) rd_ptr <= '0;
      else if (fetch)                     rd_ptr <= rd_ptr + 1'b1;
   end

   // NOTE: only the control/output flops are reset; RAM contents survive reset
   // and are never read before being rewritten by an append.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_last  <= 1'b0;
      end else if (fetch) begin
         bus.out_valid <= 1'b1;
         bus.out_data  <= bus.ram_dout;
         bus.out_last  <= fetch_last;
      end else if (state == DRAIN && out_fire) begin
         bus.out_valid <= 1'b0;
         bus.out_last  <= 1'b0;
      end
   end

endmodule
